// File: rtl/wb_burst_master.sv
// Wishbone B3 classic-cycle burst master.
// Issues single-beat accesses under one held CYC, aborts on ack timeout.
module wb_burst_master #(
   parameter int AW          = 32,
   parameter int LW          = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic [31:0]   wdata,
   input  logic          wdata_valid,
   output logic          wdata_ready,
   output logic [31:0]   rdata,
   output logic          rdata_valid,
   output logic          busy,
   output logic          timeout_err,
   output logic [AW-1:0] wb_adr_o,
   output logic [31:0]   wb_dat_o,
   output logic [3:0]    wb_sel_o,
   output logic          wb_we_o,
   output logic          wb_stb_o,
   output logic          wb_cyc_o,
   input  logic [31:0]   wb_dat_i,
   input  logic          wb_ack_i
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      WDATA,
      ACCESS
   } state_t;

   state_t        state_r, state_nx;
   logic          we_r, we_nx;
   logic [AW-1:0] adr_r, adr_nx;
   logic [31:0]   dat_r, dat_nx;
   logic [LW-1:0] cnt_r, cnt_nx;
   logic          stb_r, stb_nx;
   logic          cyc_r, cyc_nx;
   logic [31:0]   rdata_r, rdata_nx;
   logic          rvld_r, rvld_nx;
   logic          terr_r, terr_nx;
   logic [TW-1:0] tcnt_r, tcnt_nx;
   logic          ack;
   logic          last;

   // An ack only counts while the strobe is up.
   assign ack  = wb_ack_i & stb_r;
   assign last = (cnt_r == '0);

   assign busy        = (state_r != IDLE);
   assign rdata       = rdata_r;
   assign rdata_valid = rvld_r;
   assign timeout_err = terr_r;
   assign wb_adr_o    = adr_r;
   assign wb_dat_o    = dat_r;
   assign wb_sel_o    = {4{stb_r}};
   assign wb_we_o     = we_r & cyc_r;
   assign wb_stb_o    = stb_r;
   assign wb_cyc_o    = cyc_r;

   // State and datapath registers; reset drops the bus at once.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r <= IDLE;
         we_r    <= 1'b0;
         adr_r   <= '0;
         dat_r   <= '0;
         cnt_r   <= '0;
         stb_r   <= 1'b0;
         cyc_r   <= 1'b0;
         rdata_r <= '0;
         rvld_r  <= 1'b0;
         terr_r  <= 1'b0;
         tcnt_r  <= '0;
      end else begin
         state_r <= state_nx;
         we_r    <= we_nx;
         adr_r   <= adr_nx;
         dat_r   <= dat_nx;
         cnt_r   <= cnt_nx;
         stb_r   <= stb_nx;
         cyc_r   <= cyc_nx;
         rdata_r <= rdata_nx;
         rvld_r  <= rvld_nx;
         terr_r  <= terr_nx;
         tcnt_r  <= tcnt_nx;
      end
   end

   // Next-state, bus sequencing, handshakes and ack timeout.
   always_comb begin
      state_nx    = state_r;
      we_nx       = we_r;
      adr_nx      = adr_r;
      dat_nx      = dat_r;
      cnt_nx      = cnt_r;
      stb_nx      = stb_r;
      cyc_nx      = cyc_r;
      rdata_nx    = rdata_r;
      rvld_nx     = 1'b0;
      terr_nx     = 1'b0;
      tcnt_nx     = '0;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      unique case (state_r)
         IDLE: begin
            cmd_ready = ~wb_rst_i;
            stb_nx    = 1'b0;
            cyc_nx    = 1'b0;
            if (cmd_valid && !wb_rst_i) begin
               we_nx  = cmd_we;
               adr_nx = cmd_addr & ~AW'(3);
               cnt_nx = cmd_len;
               if (cmd_we) begin
                  state_nx = WDATA;
               end else begin
                  state_nx = ACCESS;
                  stb_nx   = 1'b1;
                  cyc_nx   = 1'b1;
               end
            end
         end
         WDATA: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               dat_nx   = wdata;
               state_nx = ACCESS;
               stb_nx   = 1'b1;
               cyc_nx   = 1'b1;
            end
         end
         ACCESS: begin
            if (ack) begin
               if (!we_r) begin
                  rdata_nx = wb_dat_i;
                  rvld_nx  = 1'b1;
               end
               if (last) begin
                  state_nx = IDLE;
                  stb_nx   = 1'b0;
                  cyc_nx   = 1'b0;
               end else begin
                  adr_nx = adr_r + AW'(4);
                  cnt_nx = cnt_r - LW'(1);
                  if (we_r) begin
                     if (wdata_valid) begin
                        wdata_ready = 1'b1;
                        dat_nx      = wdata;
                     end else begin
                        stb_nx   = 1'b0;
                        state_nx = WDATA;
                     end
                  end
               end
            end else if (tcnt_r == TLAST) begin
               state_nx = IDLE;
               stb_nx   = 1'b0;
               cyc_nx   = 1'b0;
               terr_nx  = 1'b1;
            end else begin
               tcnt_nx = tcnt_r + TW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            stb_nx   = 1'b0;
            cyc_nx   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: slave model, write feeder, bus monitor.
// Table of bursts plus hand sequences for timing, stall, timeout, reset.
module tb_wb_burst_master;

   logic        clk;
   logic        wb_rst_i;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wdata;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        busy;
   logic        timeout_err;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   wb_burst_master #(
      .AW(32),
      .LW(8),
      .TIMEOUT_CYC(16)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(wb_rst_i),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_we(cmd_we),
      .cmd_addr(cmd_addr),
      .cmd_len(cmd_len),
      .wdata(wdata),
      .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready),
      .rdata(rdata),
      .rdata_valid(rdata_valid),
      .busy(busy),
      .timeout_err(timeout_err),
      .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o),
      .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o),
      .wb_stb_o(wb_stb_o),
      .wb_cyc_o(wb_cyc_o),
      .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // slave model controls
   logic        slv_en;
   int          slv_lat;
   logic        slv_ack;
   logic        force_ack;
   logic [31:0] rd_xor;
   int          wcnt;

   // write feeder controls
   logic        feed_auto;
   int          feed_n;
   int          feed_gap;
   int          hs_base;
   logic [31:0] wpat [8];
   int          fk;
   int          gap_cnt;

   // monitor state
   logic [31:0] alog [$];
   logic [31:0] wlog [$];
   logic [31:0] rlog [$];
   int ncyc = 0;
   int wr_hs = 0;
   int terr_n = 0;
   int stb_n = 0;
   int cyc_n = 0;
   int stall_n = 0;
   int t_ack = 0;
   int t_rise = 0;
   int t_fall = 0;
   int t_rv = 0;
   int t_terr = 0;
   logic        terr_rdy;
   logic        fall_rdy;
   logic [31:0] rise_adr;
   logic [3:0]  rise_sel;
   logic        rise_we;
   logic        rise_cyc_prev;
   logic        p_stb = 1'b0;
   logic        p_cyc = 1'b0;

   assign wb_ack_i = slv_ack | force_ack;
   assign wb_dat_i = rd_xor ^ wb_adr_o;

   // Slave: ack each strobed beat after slv_lat wait cycles.
   always @(posedge clk) begin
      #1;
      if (wb_rst_i || !slv_en) begin
         slv_ack = 1'b0;
         wcnt = 0;
      end else if (wb_stb_o) begin
         if (wcnt == slv_lat) begin
            slv_ack = 1'b1;
            wcnt = 0;
         end else begin
            slv_ack = 1'b0;
            wcnt++;
         end
      end else begin
         slv_ack = 1'b0;
         wcnt = 0;
      end
   end

   // Feeder: present wpat beats, optionally holding beat 1 back.
   always @(posedge clk) begin
      #1;
      fk = wr_hs - hs_base;
      if (fk == 0) gap_cnt = 0;
      if (feed_auto && fk == 1 && gap_cnt < feed_gap) begin
         wdata_valid = 1'b0;
         gap_cnt++;
      end else begin
         wdata_valid = feed_auto && (fk < feed_n);
      end
      wdata = (fk >= 0 && fk < 8) ? wpat[fk] : 32'h0;
   end

   // Monitor: log beats, pulses and timestamps mid-cycle.
   always @(negedge clk) begin
      ncyc++;
      if (wb_stb_o && wb_ack_i) begin
         alog.push_back(wb_adr_o);
         if (wb_we_o) wlog.push_back(wb_dat_o);
         t_ack = ncyc;
      end
      if (rdata_valid) begin
         rlog.push_back(rdata);
         t_rv = ncyc;
      end
      if (timeout_err) begin
         terr_n++;
         terr_rdy = cmd_ready;
         t_terr = ncyc;
      end
      if (wdata_valid && wdata_ready) wr_hs++;
      if (wb_stb_o) stb_n++;
      if (wb_cyc_o) cyc_n++;
      if (wb_cyc_o && !wb_stb_o) stall_n++;
      if (wb_stb_o && !p_stb) begin
         t_rise = ncyc;
         rise_adr = wb_adr_o;
         rise_sel = wb_sel_o;
         rise_we = wb_we_o;
         rise_cyc_prev = p_cyc;
      end
      if (!wb_cyc_o && p_cyc) begin
         t_fall = ncyc;
         fall_rdy = cmd_ready;
      end
      p_stb = wb_stb_o;
      p_cyc = wb_cyc_o;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] a,
                        input logic [7:0] len);
      logic ok;
      step();
      cmd_valid = 1'b1;
      cmd_we = we;
      cmd_addr = a;
      cmd_len = len;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      cmd_valid = 1'b0;
      chk("cmd_accept", ok, 1);
   endtask

   task automatic wait_idle(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("done", busy, 0);
      step();
      step();
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  len;
      int          lat;
      logic [31:0] exp_last;
      int          exp_beats;
   } vec_t;

   vec_t tab [6];

   int ba, bw, br, bh, bs, bc, bt, bst;
   int rv0, t0;
   logic got, bad;
   logic [31:0] ea;

   initial begin
      tab[0] = '{1'b0, 32'h0000_1000, 8'd3, 0,  32'h0000_100C, 4};
      tab[1] = '{1'b0, 32'h0000_2003, 8'd1, 2,  32'h0000_2004, 2};
      tab[2] = '{1'b1, 32'h0000_3000, 8'd2, 1,  32'h0000_3008, 3};
      tab[3] = '{1'b0, 32'hFFFF_FFFC, 8'd1, 0,  32'h0000_0000, 2};
      tab[4] = '{1'b0, 32'h0000_4000, 8'd2, 15, 32'h0000_4008, 3};
      tab[5] = '{1'b1, 32'hFFFF_FFF8, 8'd2, 0,  32'h0000_0000, 3};

      wb_rst_i = 1'b1;
      cmd_valid = 1'b0;
      cmd_we = 1'b0;
      cmd_addr = '0;
      cmd_len = '0;
      slv_en = 1'b0;
      slv_lat = 0;
      slv_ack = 1'b0;
      force_ack = 1'b0;
      rd_xor = '0;
      feed_auto = 1'b0;
      feed_n = 0;
      feed_gap = 0;
      hs_base = 0;
      for (int i = 0; i < 8; i++) wpat[i] = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_sel", wb_sel_o, 0);
      chk("rst_we", wb_we_o, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", rdata_valid, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_wready", wdata_ready, 0);
      step();
      wb_rst_i = 1'b0;
      step();
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);

      // ack while idle is ignored
      br = rlog.size();
      step();
      force_ack = 1'b1;
      step();
      force_ack = 1'b0;
      step();
      @(negedge clk);
      chk("idle_ack_busy", busy, 0);
      chk("idle_ack_rv", rlog.size() - br, 0);

      // read 1 beat, ack 3 cycles after stb
      slv_en = 1'b1;
      slv_lat = 3;
      rd_xor = 32'hDEAD_BFEF;
      br = rlog.size();
      issue(1'b0, 32'h0000_0100, 8'd0);
      wait_idle(50);
      chk("r1_adr", rise_adr, 32'h100);
      chk("r1_sel", rise_sel, 4'hF);
      chk("r1_we", rise_we, 0);
      chk("r1_cyc_with_stb", rise_cyc_prev, 0);
      chk("r1_ack_lat", t_ack - t_rise, 3);
      chk("r1_rv_n", rlog.size() - br, 1);
      if (rlog.size() > br) chk("r1_rdata", rlog[br], 32'hDEADBEEF);
      chk("r1_rv_lat", t_rv - t_ack, 1);
      chk("r1_cyc_fall", t_fall - t_ack, 1);
      chk("r1_ready_back", fall_rdy, 1);

      // write 4 beats back to back
      slv_lat = 0;
      wpat[0] = 32'h11;
      wpat[1] = 32'h22;
      wpat[2] = 32'h33;
      wpat[3] = 32'h44;
      hs_base = wr_hs;
      feed_n = 4;
      feed_gap = 0;
      feed_auto = 1'b1;
      ba = alog.size();
      bw = wlog.size();
      bs = stb_n;
      bc = cyc_n;
      issue(1'b1, 32'h0000_0200, 8'd3);
      wait_idle(50);
      feed_auto = 1'b0;
      chk("w4_beats", alog.size() - ba, 4);
      for (int k = 0; k < 4; k++) begin
         if (ba + k < alog.size())
            chk("w4_adr", alog[ba + k], 32'h200 + 4 * k);
         if (bw + k < wlog.size())
            chk("w4_dat", wlog[bw + k], 32'h11 * (k + 1));
      end
      chk("w4_stb_cycles", stb_n - bs, 4);
      chk("w4_cyc_cycles", cyc_n - bc, 4);
      chk("w4_back2back", t_ack - t_rise, 3);
      chk("w4_wready", wr_hs - hs_base, 4);
      chk("w4_we", rise_we, 1);

      // write stall: beat 1 data held 5 cycles, stray ack in stall
      wpat[0] = 32'hA1;
      wpat[1] = 32'hB2;
      hs_base = wr_hs;
      feed_n = 2;
      feed_gap = 5;
      feed_auto = 1'b1;
      ba = alog.size();
      bw = wlog.size();
      bst = stall_n;
      issue(1'b1, 32'h0000_0600, 8'd1);
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wb_cyc_o && !wb_stb_o) begin
            got = 1'b1;
            break;
         end
      end
      chk("ws_stall_seen", got, 1);
      step();
      force_ack = 1'b1;
      step();
      force_ack = 1'b0;
      wait_idle(50);
      feed_auto = 1'b0;
      feed_gap = 0;
      chk("ws_beats", alog.size() - ba, 2);
      if (ba + 1 < alog.size())
         chk("ws_adr2", alog[ba + 1], 32'h604);
      if (bw + 1 < wlog.size()) begin
         chk("ws_dat1", wlog[bw], 32'hA1);
         chk("ws_dat2", wlog[bw + 1], 32'hB2);
      end
      chk("ws_stall_len", stall_n - bst, 5);
      chk("ws_wready", wr_hs - hs_base, 2);

      // table of bursts
      rd_xor = 32'h5A5A_0000;
      for (int v = 0; v < 6; v++) begin
         slv_lat = tab[v].lat;
         for (int k = 0; k < 8; k++) wpat[k] = 32'hC0DE_0000 + k;
         hs_base = wr_hs;
         feed_n = tab[v].exp_beats;
         feed_auto = tab[v].we;
         ba = alog.size();
         bw = wlog.size();
         br = rlog.size();
         bt = terr_n;
         issue(tab[v].we, tab[v].addr, tab[v].len);
         wait_idle(400);
         feed_auto = 1'b0;
         chk("tab_beats", alog.size() - ba, tab[v].exp_beats);
         if (alog.size() > ba)
            chk("tab_last_adr", alog[alog.size() - 1], tab[v].exp_last);
         for (int k = 0; k < tab[v].exp_beats; k++) begin
            ea = (tab[v].addr & 32'hFFFF_FFFC) + 32'(4 * k);
            if (ba + k < alog.size())
               chk("tab_adr", alog[ba + k], ea);
            if (tab[v].we) begin
               if (bw + k < wlog.size())
                  chk("tab_wdat", wlog[bw + k], 32'hC0DE_0000 + k);
            end else begin
               if (br + k < rlog.size())
                  chk("tab_rdat", rlog[br + k], rd_xor ^ ea);
            end
         end
         if (tab[v].we)
            chk("tab_wready", wr_hs - hs_base, tab[v].exp_beats);
         else
            chk("tab_rv_n", rlog.size() - br, tab[v].exp_beats);
         chk("tab_no_terr", terr_n - bt, 0);
      end

      // timeout: no ack at all
      slv_en = 1'b0;
      br = rlog.size();
      bt = terr_n;
      bs = stb_n;
      issue(1'b0, 32'h0000_0700, 8'd2);
      wait_idle(100);
      chk("to_stb_cycles", stb_n - bs, 16);
      chk("to_terr_n", terr_n - bt, 1);
      chk("to_terr_at", t_terr - t_rise, 16);
      chk("to_cyc_fall", t_fall, t_terr);
      chk("to_ready", terr_rdy, 1);
      chk("to_no_rv", rlog.size() - br, 0);

      // reset mid-burst after beat 2 ack
      slv_en = 1'b1;
      slv_lat = 1;
      ba = alog.size();
      bt = terr_n;
      issue(1'b0, 32'h0000_5000, 8'd7);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (alog.size() - ba >= 2) begin
            got = 1'b1;
            break;
         end
      end
      chk("mr_two_beats", got, 1);
      @(posedge clk);
      #3;
      wb_rst_i = 1'b1;
      #1;
      chk("mr_cyc_async", wb_cyc_o, 0);
      chk("mr_stb_async", wb_stb_o, 0);
      chk("mr_cmd_ready", cmd_ready, 0);
      rv0 = rlog.size();
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (wb_cyc_o || wb_stb_o || cmd_ready || busy || rdata_valid)
            bad = 1'b1;
      end
      chk("mr_hold", bad, 0);
      step();
      wb_rst_i = 1'b0;
      repeat (10) step();
      chk("mr_no_rv", rlog.size() - rv0, 0);
      chk("mr_no_terr", terr_n - bt, 0);
      chk("mr_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
